// File: rtl/gold_pkg.sv
// Shared Gold-code definitions: register geometry, seeding, feedback taps and
// the correlator state encoding.
package gold_pkg;

  localparam int unsigned LFSR_LEN    = 15;
  localparam int unsigned CODE_PERIOD = 32767;
  localparam int unsigned SEED_W      = 6;

  localparam logic [LFSR_LEN-1:0] A_INIT = 15'h4000;
  // Feedback masks: new MSB is the XOR of the masked bits.
  localparam logic [LFSR_LEN-1:0] A_TAPS = 15'h0003;
  localparam logic [LFSR_LEN-1:0] B_TAPS = 15'h100B;

  function automatic logic [LFSR_LEN-1:0] b_init(input logic [SEED_W-1:0] seed);
    return {1'b0, 1'b1, 7'b0, seed};
  endfunction

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSearch = 2'd1,
    StSlip   = 2'd2,
    StLocked = 2'd3
  } state_e;

endpackage

// File: rtl/gold_code_gen.sv
// Gold chip generator: two 15-bit Fibonacci LFSRs whose LSBs are XORed.
// Same sequence logic as the transmitter; load wins over advance.
module gold_code_gen
  import gold_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic [SEED_W-1:0] seed_i,
  output logic              chip_o
);

  logic [LFSR_LEN-1:0] a_q, a_d;
  logic [LFSR_LEN-1:0] b_q, b_d;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (load_i) begin
      a_d = A_INIT;
      b_d = b_init(seed_i);
    end else if (advance_i) begin
      a_d = {^(a_q & A_TAPS), a_q[LFSR_LEN-1:1]};
      b_d = {^(b_q & B_TAPS), b_q[LFSR_LEN-1:1]};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
    end
  end

  assign chip_o = a_q[0] ^ b_q[0];

endmodule

// File: rtl/gold_code_correlator.sv
// Serial code-phase search correlator: integrates chip agreements per window,
// slips the local code one chip per failed window, and tracks loss of lock.
module gold_code_correlator
  import gold_pkg::*;
#(
  parameter int unsigned Window     = 64,
  parameter int unsigned LockThresh = 56,
  parameter int unsigned LossThresh = 40,
  parameter int unsigned MaxMisses  = 2,
  localparam int unsigned CntW      = $clog2(Window + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [SEED_W-1:0] seed_i,
  input  logic              chip_valid_i,
  input  logic              chip_in_i,
  output logic              locked_o,
  output logic [1:0]        state_o,
  output logic [CntW-1:0]   agree_last_o,
  output logic              window_done_o,
  output logic [14:0]       slip_count_o,
  output logic              local_chip_o
);

  localparam int unsigned MissW = $clog2(MaxMisses + 1);

  localparam logic [CntW-1:0]  LastChip = CntW'(Window - 1);
  localparam logic [CntW-1:0]  LockThr  = CntW'(LockThresh);
  localparam logic [CntW-1:0]  LossThr  = CntW'(LossThresh);
  localparam logic [MissW-1:0] MissMax  = MissW'(MaxMisses);
  localparam logic [14:0]      SlipMax  = 15'(CODE_PERIOD - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   agree_q, agree_d;
  logic [CntW-1:0]   chips_q, chips_d;
  logic [CntW-1:0]   agree_last_q, agree_last_d;
  logic              window_done_q, window_done_d;
  logic [14:0]       slip_count_q, slip_count_d;
  logic [MissW-1:0]  misses_q, misses_d;
  logic              locked_q;

  logic              local_chip;
  logic              active;
  logic              advance;
  logic              gen_load;
  logic [CntW-1:0]   agree_now;
  logic [MissW-1:0]  misses_inc;

  gold_code_gen u_gen (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (gen_load),
    .advance_i (advance),
    .seed_i    (seed_i),
    .chip_o    (local_chip)
  );

  assign active     = chip_valid_i && (state_q == StSearch || state_q == StLocked);
  assign agree_now  = agree_q + CntW'(chip_in_i == local_chip);
  assign misses_inc = misses_q + MissW'(1);
  assign gen_load   = start_i;
  assign advance    = active && !start_i;

  always_comb begin
    state_d       = state_q;
    agree_d       = agree_q;
    chips_d       = chips_q;
    agree_last_d  = agree_last_q;
    window_done_d = 1'b0;
    slip_count_d  = slip_count_q;
    misses_d      = misses_q;

    if (start_i) begin
      state_d      = StSearch;
      agree_d      = '0;
      chips_d      = '0;
      slip_count_d = '0;
      misses_d     = '0;
    end else if (active) begin
      if (chips_q == LastChip) begin
        agree_last_d  = agree_now;
        window_done_d = 1'b1;
        agree_d       = '0;
        chips_d       = '0;
        if (state_q == StSearch) begin
          if (agree_now >= LockThr) begin
            state_d  = StLocked;
            misses_d = '0;
          end else begin
            state_d      = StSlip;
            slip_count_d = (slip_count_q == SlipMax) ? '0 : slip_count_q + 15'd1;
          end
        end else if (agree_now < LossThr) begin
          // Loss drops back to search without slipping: phase is likely still close.
          if (misses_inc >= MissMax) begin
            state_d  = StSearch;
            misses_d = '0;
          end else begin
            misses_d = misses_inc;
          end
        end else begin
          misses_d = '0;
        end
      end else begin
        agree_d = agree_now;
        chips_d = chips_q + CntW'(1);
      end
    end else if (state_q == StSlip && chip_valid_i) begin
      // Discarding this chip without advancing retards the local code by one.
      state_d = StSearch;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      agree_q       <= '0;
      chips_q       <= '0;
      agree_last_q  <= '0;
      window_done_q <= 1'b0;
      slip_count_q  <= '0;
      misses_q      <= '0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      agree_q       <= agree_d;
      chips_q       <= chips_d;
      agree_last_q  <= agree_last_d;
      window_done_q <= window_done_d;
      slip_count_q  <= slip_count_d;
      misses_q      <= misses_d;
      locked_q      <= (state_d == StLocked);
    end
  end

  assign locked_o      = locked_q;
  assign state_o       = state_q;
  assign agree_last_o  = agree_last_q;
  assign window_done_o = window_done_q;
  assign slip_count_o  = slip_count_q;
  assign local_chip_o  = local_chip;

endmodule

// File: tb/tb_gold_code_correlator.sv
// Bench for gold_code_correlator: phase-indexed reference model checked every
// cycle, plus directed scenario checks with literal expectations.
module tb_gold_code_correlator;

  localparam int PERIOD = 32767;
  localparam int WINDOW = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [5:0] seed = 6'h2A;
  logic       chip_valid = 1'b0;
  logic       chip_in = 1'b0;
  logic       locked_o;
  logic [1:0] state_o;
  logic [6:0] agree_last_o;
  logic       window_done_o;
  logic [14:0] slip_count_o;
  logic       local_chip_o;

  gold_code_correlator dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .seed_i        (seed),
    .chip_valid_i  (chip_valid),
    .chip_in_i     (chip_in),
    .locked_o      (locked_o),
    .state_o       (state_o),
    .agree_last_o  (agree_last_o),
    .window_done_o (window_done_o),
    .slip_count_o  (slip_count_o),
    .local_chip_o  (local_chip_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  bit code [PERIOD];
  int tx_idx = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Full code period straight from the LFSR definitions.
  task automatic build_code(input logic [5:0] s);
    logic [14:0] a, b;
    logic na, nb;
    a = 15'h4000;
    b = {1'b0, 1'b1, 7'b0, s};
    for (int i = 0; i < PERIOD; i++) begin
      code[i] = a[0] ^ b[0];
      na = a[0] ^ a[1];
      nb = b[0] ^ b[1] ^ b[3] ^ b[12];
      a = {na, a[14:1]};
      b = {nb, b[14:1]};
    end
  endtask

  // Reference model: local code tracked as a phase index into the code table.
  int m_state, m_agree, m_chips, m_last, m_slips, m_miss, m_phase;
  bit m_wd, m_loaded, m_lchip;

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0; m_agree = 0; m_chips = 0; m_last = 0; m_slips = 0;
      m_miss = 0; m_phase = 0; m_wd = 0; m_loaded = 0;
    end else begin
      m_wd = 0;
      if (start) begin
        m_state = 1; m_agree = 0; m_chips = 0; m_slips = 0; m_miss = 0;
        m_phase = 0; m_loaded = 1;
      end else if (chip_valid) begin
        if (m_state == 1 || m_state == 3) begin
          if (chip_in == code[m_phase]) m_agree++;
          m_chips++;
          m_phase = (m_phase + 1) % PERIOD;
          if (m_chips == WINDOW) begin
            m_last = m_agree;
            m_wd = 1;
            if (m_state == 1) begin
              if (m_agree >= 56) begin
                m_state = 3; m_miss = 0;
              end else begin
                m_state = 2; m_slips = (m_slips + 1) % PERIOD;
              end
            end else begin
              m_miss = (m_agree < 40) ? m_miss + 1 : 0;
              if (m_miss >= 2) begin
                m_state = 1; m_miss = 0;
              end
            end
            m_agree = 0; m_chips = 0;
          end
        end else if (m_state == 2) begin
          m_state = 1;
        end
      end
    end
    m_lchip = m_loaded ? code[m_phase] : 1'b0;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_state", int'(state_o), m_state);
      chk("model_locked", int'(locked_o), int'(m_state == 3));
      chk("model_agree_last", int'(agree_last_o), m_last);
      chk("model_window_done", int'(window_done_o), int'(m_wd));
      chk("model_slip_count", int'(slip_count_o), m_slips);
      chk("model_local_chip", int'(local_chip_o), int'(m_lchip));
    end
  end

  task automatic step(input bit v, input bit c, input bit st, input bit r);
    chip_valid = v;
    chip_in    = c;
    start      = st;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  // Send n reference chips, one every gap cycles, optionally inverted or flipped.
  task automatic send(input int n, input int gap, input bit inv, input logic [63:0] flips);
    for (int i = 0; i < n; i++) begin
      for (int g = 1; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, code[tx_idx] ^ inv ^ ((i < 64) ? flips[i] : 1'b0), 1'b0, 1'b0);
      tx_idx = (tx_idx + 1) % PERIOD;
    end
  endtask

  task automatic restart(input logic [5:0] s, input bit v);
    build_code(s);
    seed   = s;
    tx_idx = 0;
    step(v, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic [63:0] rand_flips(input int k);
    logic [63:0] m;
    int cnt, p;
    m = '0;
    cnt = 0;
    while (cnt < k) begin
      p = $urandom_range(63);
      if (!m[p]) begin
        m[p] = 1'b1;
        cnt++;
      end
    end
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] rs;
    build_code(6'h2A);
    chk("code_chip0", int'(code[0]), 0);
    chk("code_chip1", int'(code[1]), 1);
    chk("code_chip2", int'(code[2]), 0);

    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_state", int'(state_o), 0);
    chk("reset_locked", int'(locked_o), 0);
    chk("reset_agree_last", int'(agree_last_o), 0);
    chk("reset_window_done", int'(window_done_o), 0);
    chk("reset_slip", int'(slip_count_o), 0);
    chk("reset_local_chip", int'(local_chip_o), 0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_ignores_chips", int'(state_o), 0);

    // Aligned lock.
    restart(6'h2A, 1'b0);
    send(64, 1, 1'b0, '0);
    chk("aligned_window_done", int'(window_done_o), 1);
    chk("aligned_agree", int'(agree_last_o), 64);
    chk("aligned_locked", int'(locked_o), 1);
    chk("aligned_slip", int'(slip_count_o), 0);

    // One bad window does not drop lock.
    send(64, 1, 1'b1, '0);
    chk("single_miss_agree", int'(agree_last_o), 0);
    chk("single_miss_locked", int'(locked_o), 1);
    send(64, 1, 1'b0, '0);
    chk("single_miss_recover", int'(locked_o), 1);

    // Two consecutive bad windows drop to SEARCH without slipping.
    send(64, 1, 1'b1, '0);
    chk("loss_w1_locked", int'(locked_o), 1);
    send(64, 1, 1'b1, '0);
    chk("loss_w2_agree", int'(agree_last_o), 0);
    chk("loss_w2_locked", int'(locked_o), 0);
    chk("loss_w2_state", int'(state_o), 1);
    chk("loss_w2_slip", int'(slip_count_o), 0);
    send(64, 1, 1'b0, '0);
    chk("relock", int'(locked_o), 1);

    // 20 flipped chips per window stays above the loss threshold.
    for (int w = 0; w < 3; w++) begin
      send(64, 1, 1'b0, rand_flips(20));
      chk("noise_agree", int'(agree_last_o), 44);
      chk("noise_locked", int'(locked_o), 1);
    end

    // Stream delayed 5 chips: five slips then lock.
    restart(6'h2A, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(1)), 1'b0, 1'b0);
    tx_idx = 0;
    for (int k = 0; k < 800 && !locked_o; k++) send(1, 1, 1'b0, '0);
    chk("delayed_locked", int'(locked_o), 1);
    chk("delayed_slips", int'(slip_count_o), 5);
    chk("delayed_agree", int'(agree_last_o), 64);

    // Gapped valid: lock lands exactly 192 cycles after start.
    restart(6'h2A, 1'b0);
    send(63, 3, 1'b0, '0);
    chk("gapped_not_yet", int'(locked_o), 0);
    send(1, 3, 1'b0, '0);
    chk("gapped_locked", int'(locked_o), 1);
    chk("gapped_agree", int'(agree_last_o), 64);

    // Restart mid-window with a new seed while locked.
    send(30, 1, 1'b0, '0);
    restart(6'h15, 1'b1);
    chk("restart_state", int'(state_o), 1);
    chk("restart_locked", int'(locked_o), 0);
    send(63, 1, 1'b0, '0);
    chk("restart_no_early_done", int'(window_done_o), 0);
    send(1, 1, 1'b0, '0);
    chk("restart_locked_again", int'(locked_o), 1);
    chk("restart_agree", int'(agree_last_o), 64);

    // rst beats start while locked.
    step(1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_prio_state", int'(state_o), 0);
    chk("rst_prio_locked", int'(locked_o), 0);
    chk("rst_prio_agree", int'(agree_last_o), 0);
    chk("rst_prio_slip", int'(slip_count_o), 0);
    chk("rst_prio_local", int'(local_chip_o), 0);

    // Randomized traffic: random seed, offset, gaps, noise and occasional restarts.
    for (int r = 0; r < 3; r++) begin
      rs = 6'($urandom_range(63));
      restart(rs, 1'b0);
      tx_idx = $urandom_range(12);
      for (int c = 0; c < 600; c++) begin
        if ($urandom_range(199) == 0) begin
          restart(rs, 1'($urandom_range(1)));
        end else if ($urandom_range(3) == 0) begin
          step(1'b0, 1'($urandom_range(1)), 1'b0, 1'b0);
        end else begin
          step(1'b1, code[tx_idx] ^ ($urandom_range(15) == 0), 1'b0, 1'b0);
          tx_idx = (tx_idx + 1) % PERIOD;
        end
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
